// File: rtl/etapa_pkg.sv
// Shared definitions for the BRAM frame writer: default geometry,
// the sample type, the writer state encoding and the acknowledge timeout.
package etapa_pkg;

    localparam int DATA_W_DEF  = 17;
    localparam int ADDR_W_DEF  = 8;
    localparam int DEPTH_DEF   = 144;
    localparam int ACK_TIMEOUT = 16;

    typedef logic [DATA_W_DEF-1:0] sample_t;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        DONE      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_FREE = 2'd3
    } wr_state_t;

endpackage

// File: rtl/frame_addr_ctr.sv
// Frame write pointer: counts 0..DEPTH-1, wraps to 0 after the last slot,
// can be cleared early, and flags the terminal slot.
module frame_addr_ctr
    import etapa_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              tc_o
);

    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Next pointer: clear wins over increment; the last slot wraps to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST_SLOT) ? '0 : ptr_q + ADDR_W'(1);
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
    assign tc_o  = (ptr_q == LAST_SLOT);

endmodule

// File: rtl/bram_frame_writer.sv
// Streams samples into BRAM port A, one frame of DEPTH samples at a time,
// then hands the frame to the reader and waits for it to become free.
// Optional feature: define LAST_CHECK_EN to check s_last against the frame
// boundary and report mismatches on frame_err.
module bram_frame_writer
    import etapa_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              busy,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              data_done,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

    localparam logic [4:0] ACK_LIMIT = 5'(ACK_TIMEOUT);

    wr_state_t         state_q, state_d;
    logic [4:0]        timer_q, timer_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic              ptr_tc;
    logic              xfer;
    logic              last_err;
    logic              frame_end;

    logic              wea_q;
    logic [ADDR_W-1:0] addra_q;
    logic [DATA_W-1:0] dina_q;
    logic              data_done_q;
    logic              frame_err_q;
    logic [15:0]       frame_cnt_q;

    // Only accept samples while filling and out of reset.
    assign s_ready = reset && (state_q == FILL);
    assign xfer    = s_valid && s_ready;

`ifdef LAST_CHECK_EN
    // s_last must coincide exactly with the terminal slot.
    assign last_err = xfer && (s_last != ptr_tc);
`else
    logic unused_last;
    assign unused_last = s_last;
    assign last_err    = 1'b0;
`endif

    // A frame completes only on a clean transfer into the terminal slot.
    assign frame_end = xfer && ptr_tc && !last_err;

    frame_addr_ctr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_ctr (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (xfer),
        .clr_i  (last_err),
        .ptr_o  (wr_ptr),
        .tc_o   (ptr_tc)
    );

    // Next-state logic; the ack timer counts idle cycles while in WAIT_ACK.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            FILL: begin
                if (frame_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = WAIT_ACK;
                timer_d = '0;
            end
            WAIT_ACK: begin
                if (busy) begin
                    state_d = WAIT_FREE;
                end else if (timer_q == ACK_LIMIT) begin
                    state_d = FILL;
                end else begin
                    timer_d = timer_q + 5'd1;
                end
            end
            WAIT_FREE: begin
                if (!busy) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and timer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FILL;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Registered BRAM port and status pulses; data_done follows the DONE cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wea_q       <= 1'b0;
            addra_q     <= '0;
            dina_q      <= '0;
            data_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wea_q       <= xfer;
            if (xfer) begin
                addra_q <= wr_ptr;
                dina_q  <= s_data;
            end
            data_done_q <= (state_q == DONE);
            frame_err_q <= last_err;
            if (state_q == DONE) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign data_done = data_done_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bram_frame_writer.sv
// Scoreboard bench for bram_frame_writer: the driver queues expected BRAM
// writes as samples are accepted; a monitor pops and compares them.
module tb_bram_frame_writer;
    import etapa_pkg::*;

    localparam int DEPTH  = DEPTH_DEF;
    localparam int ADDR_W = ADDR_W_DEF;

    logic              clk     = 1'b0;
    logic              reset   = 1'b0;
    logic              s_valid = 1'b0;
    sample_t           s_data  = '0;
    logic              s_last  = 1'b0;
    logic              busy    = 1'b0;
    logic              s_ready;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    sample_t           dina;
    logic              data_done;
    logic              frame_err;
    logic [15:0]       frame_cnt;

    always #5 clk = ~clk;

    bram_frame_writer dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .busy      (busy),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .data_done (data_done),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        sample_t           data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  errors     = 0;
    int  checks     = 0;
    int  cyc        = 0;
    int  exp_ptr    = 0;
    int  exp_frames = 0;
    int  done_cnt   = 0;
    int  err_cnt    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every BRAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (wea) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: addr %0d data %0d, required no write", addra, dina);
            end else begin
                mon_e = exp_q.pop_front();
                if (addra !== mon_e.addr || dina !== mon_e.data) begin
                    errors++;
                    $display("FAIL write: addr %0d data %0d, required addr %0d data %0d",
                             addra, dina, mon_e.addr, mon_e.data);
                end
            end
        end
        if (data_done) begin
            done_cnt++;
            check("frame_cnt_at_done", int'(frame_cnt), exp_frames);
        end
        if (frame_err) err_cnt++;
    end

    // Present one sample until accepted; queue its expected write.
    task automatic send_word(input sample_t d, input logic last, output int tcyc);
        bit   accepted;
        bit   err;
        wr_t  e;
        accepted = 1'b0;
        tcyc     = -1;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clk);
            if (s_ready) begin
                tcyc   = cyc;
                e.addr = ADDR_W'(exp_ptr);
                e.data = d;
                exp_q.push_back(e);
`ifdef LAST_CHECK_EN
                err = (last != (exp_ptr == DEPTH - 1));
`else
                err = 1'b0;
`endif
                if (err) begin
                    exp_ptr = 0;
                end else if (exp_ptr == DEPTH - 1) begin
                    exp_ptr = 0;
                    exp_frames++;
                end else begin
                    exp_ptr++;
                end
                accepted = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sample %0d not accepted, required acceptance within 200 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the cycle showing data_done.
    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int k = 0; k < 300 && dcyc < 0; k++) begin
            @(negedge clk);
            if (data_done) dcyc = cyc;
        end
        if (dcyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no data_done, required one within 300 cycles");
        end
    endtask

    initial begin
        int t0, t1, dcyc, rcyc, d0, e0, hi;
        t0 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_wea", wea, 0);
        check("rst_addra", int'(addra), 0);
        check("rst_dina", int'(dina), 0);
        check("rst_data_done", data_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("s_ready_after_rst", s_ready, 1);
        @(posedge clk); #1;

        // Scenario 1: back-to-back frame, then scenario 4: ack timeout
        for (int i = 0; i < DEPTH; i++) begin
            send_word(sample_t'(i), (i == DEPTH - 1), t1);
            if (i == 0) t0 = t1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("s1_back_to_back", t1 - t0, DEPTH - 1);
        wait_done(dcyc);
        check("s1_done_latency", dcyc - t1, 2);
        check("s1_frame_cnt", int'(frame_cnt), 1);
        rcyc = -1;
        for (int k = 0; k < 40 && rcyc < 0; k++) begin
            @(negedge clk);
            if (s_ready) rcyc = cyc;
        end
        check("s4_timeout_ready", rcyc - dcyc, 17);
        @(posedge clk); #1;
        check("s1_done_count", done_cnt, 1);

        // Scenario 2: random 50% valid over a full frame
        d0 = done_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            send_word(sample_t'(1000 + i), (i == DEPTH - 1), t1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done(dcyc);

        // Scenario 3: busy for 20 cycles after data_done
        @(posedge clk); #1;
        busy = 1'b1;
        check("s2_one_done", done_cnt - d0, 1);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_ready) hi++;
        end
        check("s3_ready_while_busy", hi, 0);
        @(posedge clk); #1;
        busy = 1'b0;
        @(negedge clk);
        check("s3_ready_busy_fall_cycle", s_ready, 0);
        @(negedge clk);
        check("s3_ready_after_busy", s_ready, 1);
        @(posedge clk); #1;
        send_word(sample_t'(5), 1'b0, t1);

        // Scenario 5: reset after 70 transfers
        for (int i = 1; i < 70; i++) send_word(sample_t'(2000 + i), 1'b0, t1);
        idle(2);
        d0 = done_cnt;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("s5_wea_in_reset", wea, 0);
        check("s5_frame_cnt_in_reset", int'(frame_cnt), 0);
        exp_ptr    = 0;
        exp_frames = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        idle(3);
        check("s5_no_done", done_cnt - d0, 0);
        for (int i = 0; i < DEPTH; i++) send_word(sample_t'(3000 + i), (i == DEPTH - 1), t1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done(dcyc);
        @(posedge clk); #1;
        check("s5_frame_cnt", int'(frame_cnt), 1);

        // Scenario 6: s_last on sample 99
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 100; i++) send_word(sample_t'(4000 + i), (i == 99), t1);
        idle(2);
`ifdef LAST_CHECK_EN
        check("s6_frame_err_pulses", err_cnt - e0, 1);
`else
        check("s6_frame_err_tied", err_cnt - e0, 0);
`endif
        send_word(sample_t'(4100), 1'b0, t1);
        idle(3);
        check("s6_no_done", done_cnt - d0, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_frame_writer.md
BRAM_FRAME_WRITER -- requirements
Module: bram_frame_writer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have parameter DEPTH, default 144, giving the number of samples per frame.
REQ-003 The block SHALL have parameter DATA_W, default 17, giving the sample width.
REQ-004 The block SHALL have parameter ADDR_W, default 8, giving the BRAM address width.
REQ-005 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: the synchronous reset, active-low.
REQ-007 The block SHALL have port s_valid, input, 1 bit: the upstream sample is valid.
REQ-008 The block SHALL have port s_data, input, DATA_W bits: the upstream sample.
REQ-009 The block SHALL have port s_last, input, 1 bit: the upstream end-of-frame marker.
REQ-010 The block SHALL have port s_ready, output, 1 bit: the writer accepts a sample.
REQ-011 The block SHALL have port busy, input, 1 bit: the busy flag of the downstream BRAM reader.
REQ-012 The block SHALL have port wea, output, 1 bit: the BRAM port-A write enable.
REQ-013 The block SHALL have port addra, output, ADDR_W bits: the BRAM port-A address.
REQ-014 The block SHALL have port dina, output, DATA_W bits: the BRAM port-A write data.
REQ-015 The block SHALL have port data_done, output, 1 bit: a one-cycle pulse meaning the frame is complete in BRAM.
REQ-016 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse meaning a framing error occurred.
REQ-017 The block SHALL have port frame_cnt, output, 16 bits: the count of completed frames, wrapping at 2^16.

Function
REQ-018 The state machine SHALL have the states FILL, DONE, WAIT_ACK and WAIT_FREE.
REQ-019 s_ready SHALL be 1 only in FILL; a transfer is s_valid && s_ready at a rising clock edge.
REQ-020 On a transfer, wea, addra and dina SHALL be registered: one cycle of latency, with wea=1, addra=wr_ptr and dina=s_data.
REQ-021 In any cycle without a transfer on the previous edge, wea SHALL be 0; addra and dina SHALL hold their values.
REQ-022 wr_ptr SHALL increment by 1 per transfer; the transfer at wr_ptr=DEPTH-1 SHALL reset wr_ptr to 0 and move the state machine to DONE.
REQ-023 DONE SHALL last exactly one cycle, beginning the cycle after the last wea=1 cycle, and SHALL assert data_done=1; frame_cnt SHALL increment in the same cycle.
REQ-024 WAIT_ACK SHALL go to WAIT_FREE when busy=1, and SHALL go to FILL after 16 cycles without busy=1 (timeout).
REQ-025 WAIT_FREE SHALL go to FILL on the first cycle with busy=0.
REQ-026 s_valid while the block is not in FILL SHALL be back-pressured (s_ready=0) and no data SHALL be lost.
REQ-027 busy SHALL be ignored while in FILL.
REQ-028 wr_ptr SHALL never exceed DEPTH-1, and addra SHALL never be written outside 0..DEPTH-1.

Reset
REQ-029 When reset=0 at a clock edge, the block SHALL go to state FILL with wr_ptr=0, wea=0, addra=0, dina=0, data_done=0, frame_err=0 and frame_cnt=0.
REQ-030 Reset in the middle of a frame SHALL discard the partial frame, and data_done SHALL NOT be asserted for it.
REQ-031 s_ready SHALL be 0 during reset and SHALL be 1 in the first cycle after reset returns to 1.

Configuration
REQ-032 With LAST_CHECK_EN defined, a transfer with s_last=1 at wr_ptr != DEPTH-1, or with s_last=0 at wr_ptr=DEPTH-1, SHALL pulse frame_err for one cycle.
REQ-033 With LAST_CHECK_EN defined, the same framing error SHALL set wr_ptr to 0 and keep the state at FILL; no data_done and no frame_cnt increment SHALL occur.
REQ-034 With LAST_CHECK_EN defined, the erroneous sample SHALL still be written to BRAM.
REQ-035 Without LAST_CHECK_EN, s_last SHALL be ignored and frame_err SHALL be tied to 0.

Structure
REQ-036 The shared package etapa_pkg SHALL hold the DATA_W, ADDR_W and DEPTH defaults, the typedef sample_t (logic [DATA_W-1:0]), the enum wr_state_t and the constant ACK_TIMEOUT=16.
REQ-037 A single sub-module, frame_addr_ctr, SHALL hold wr_ptr with its wrap and terminal-count flag; all other logic SHALL be inline.

Verification
REQ-038 Bench scenario 1: reset, then 144 back-to-back transfers of data=i -> wea=1 at addresses 0..143 in 144 consecutive cycles, data_done=1 exactly 1 cycle after address 143, and frame_cnt=1.
REQ-039 Bench scenario 2: s_valid toggled at random 50% over a full frame -> 144 writes in address order with no gaps in data, and exactly one data_done pulse.
REQ-040 Bench scenario 3: after data_done, busy=1 for 20 cycles then 0 -> s_ready=0 throughout, s_ready=1 in the cycle after busy falls, and the next write goes to address 0.
REQ-041 Bench scenario 4: busy held at 0 after data_done -> s_ready returns to 1 exactly 17 cycles after data_done (16-cycle timeout).
REQ-042 Bench scenario 5: reset=0 after 70 transfers -> wea=0 and no data_done; the next frame starts at address 0 and frame_cnt=0.
REQ-043 Bench scenario 6 (LAST_CHECK_EN): s_last=1 on sample 99 -> frame_err pulses once, the next write goes to address 0, and no data_done occurs.
